// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider and its slow-domain consumers.
// Holds the monitor FSM encoding, the lock run length and a range helper.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_ACQ     = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_STALLED = 2'd2
  } mon_state_t;

  // Consecutive in-range periods needed before declaring lock.
  localparam int LOCK_RUN = 2;

  // True when p lies within exp_p +/- tol (inclusive).
  function automatic logic in_range(
    input int p,
    input int exp_p,
    input int tol
  );
    return (p >= exp_p - tol) && (p <= exp_p + tol);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Samples an asynchronous slow clock into the fast domain and produces
// registered one-cycle rise/fall strobes from the synchronised level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Shift the input through the chain and compare the newest level to the last one.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    s      = sync_q[SYNC_STAGES-1];
    prev_d = s;
    rise_d = s & ~prev_q;
    fall_d = ~s & prev_q;
  end

  // Chain, history and strobe registers; reset forgets all pre-reset history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow clock consumer: edge strobes, rise-to-rise period, lock and stall status.
// Stall detection is built only when SLOW_CLK_MONITOR_STALL_DETECT_EN is defined.
module slow_clk_monitor
  import clk_div_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 12,
  parameter int TOL         = 1,
  parameter int STALL_LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2 || STALL_LIMIT >= 2**CNT_W ||
      EXP_PERIOD + TOL >= 2**CNT_W - 1) begin : g_cfg_err
    $error("slow_clk_monitor: illegal parameter combination");
  end

  mon_state_t       state_q, state_d;
  logic [1:0]       run_q, run_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] p_new;
  logic             vld_q, vld_d;
  logic             first_q, first_d;
  logic             locked_q, stall_q;
  logic             stall_hit;
  logic             enter_stall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .reset(reset),
    .din  (slow_clk),
    .rise (rise_tick),
    .fall (fall_tick)
  );

  // Period counter; the first rise after reset or a stall only restarts it.
  always_comb begin
    p_new    = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_W'(1);
    pcnt_d   = rise_tick ? '0 : p_new;
    vld_d    = rise_tick & ~first_q;
    period_d = vld_d ? p_new : period_q;
    first_d  = first_q;
    if (rise_tick)   first_d = 1'b0;
    if (enter_stall) first_d = 1'b1;
  end

`ifdef SLOW_CLK_MONITOR_STALL_DETECT_EN
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);
  logic [CNT_W-1:0] scnt_q, scnt_d;

  // Cycles since the last edge of either polarity; an edge beats the timeout.
  always_comb begin
    scnt_d = (scnt_q == STALL_MAX) ? scnt_q : scnt_q + CNT_W'(1);
    if (rise_tick | fall_tick) scnt_d = '0;
    stall_hit = (scnt_d == STALL_MAX);
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scnt_q <= '0;
    else       scnt_q <= scnt_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Lock FSM next state: judges each reported period, watches for stalls.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    enter_stall = 1'b0;
    unique case (state_q)
      ST_ACQ: begin
        if (stall_hit) begin
          state_d     = ST_STALLED;
          run_d       = '0;
          enter_stall = 1'b1;
        end else if (vld_q) begin
          if (in_range(int'(period_q), EXP_PERIOD, TOL)) begin
            if (run_q + 2'd1 == 2'(LOCK_RUN)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 2'd1;
            end
          end else begin
            run_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (stall_hit) begin
          state_d     = ST_STALLED;
          run_d       = '0;
          enter_stall = 1'b1;
        end else if (vld_q &&
                     !in_range(int'(period_q), EXP_PERIOD, TOL)) begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
      end
      ST_STALLED: begin
        if (rise_tick) begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACQ;
        run_d   = '0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ACQ;
      run_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b1;
      locked_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
      locked_q <= (state_d == ST_LOCKED);
      stall_q  <= (state_d == ST_STALLED);
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor: divider-like and random slow_clk stimulus,
// expectations queued by a reference model and checked by a monitor.
module tb_slow_clk_monitor;

  localparam int EXP  = 12;
  localparam int TOL  = 1;
  localparam int LIM  = 32;
  localparam int PMAX = 255;
  localparam int LAT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b0;
  logic       rise_tick, fall_tick, period_vld, locked, stall;
  logic [7:0] period;

  slow_clk_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .period    (period),
    .period_vld(period_vld),
    .locked    (locked),
    .stall     (stall)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
  } ev_t;

  int  rq[$];
  int  fq[$];
  ev_t vq[$];
  ev_t lq[$];
  ev_t sq[$];

  int total = 0;
  int bad   = 0;

  bit cur_lock  = 1'b0;
  bit cur_stall = 1'b0;
  bit in_rst    = 1'b1;

  bit m_prev;
  bit m_first;
  bit m_lock;
  bit m_stalled;
  int m_run;
  int m_last;
  int m_since;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    fq.delete();
    vq.delete();
    lq.delete();
    sq.delete();
    cur_lock  = 1'b0;
    cur_stall = 1'b0;
    m_prev    = 1'b0;
    m_first   = 1'b1;
    m_lock    = 1'b0;
    m_stalled = 1'b0;
    m_run     = 0;
    m_last    = 0;
    m_since   = LAT;
  endtask

  // Level applied after edge e becomes visible as a tick LAT cycles later.
  task automatic model_step(input int e, input bit lvl);
    int  c;
    int  p;
    bit  r;
    bit  f;
    c = e + LAT;
    r = lvl && !m_prev;
    f = !lvl && m_prev;
    m_prev = lvl;
    if (r || f) m_since = 0;
    else if (m_since < LIM) m_since++;
    if (r) rq.push_back(c);
    if (f) fq.push_back(c);
    if (r) begin
      if (m_first) begin
        m_first = 1'b0;
        m_last  = c;
        if (m_stalled) begin
          m_stalled = 1'b0;
          sq.push_back('{c + 1, 0});
        end
      end else begin
        p = c - m_last;
        if (p > PMAX) p = PMAX;
        m_last = c;
        vq.push_back('{c + 1, p});
        if (p >= EXP - TOL && p <= EXP + TOL) begin
          m_run++;
          if (!m_lock && m_run >= 2) begin
            m_lock = 1'b1;
            m_run  = 0;
            lq.push_back('{c + 2, 1});
          end
        end else begin
          m_run = 0;
          if (m_lock) begin
            m_lock = 1'b0;
            lq.push_back('{c + 2, 0});
          end
        end
      end
    end
`ifdef SLOW_CLK_MONITOR_STALL_DETECT_EN
    if (!r && !f && m_since == LIM && !m_stalled) begin
      m_stalled = 1'b1;
      m_first   = 1'b1;
      m_run     = 0;
      sq.push_back('{c + 1, 1});
      if (m_lock) begin
        m_lock = 1'b0;
        lq.push_back('{c + 1, 0});
      end
    end
`endif
  endtask

  task automatic step(input bit lvl, input bit rst_v);
    @(posedge clk);
    #1;
    reset    = rst_v;
    slow_clk = lvl;
    if (rst_v) begin
      model_reset();
      in_rst = 1'b1;
    end else begin
      if (in_rst) begin
        model_reset();
        in_rst = 1'b0;
      end
      model_step(cyc, lvl);
    end
  endtask

  task automatic periods(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  task automatic hold(input int n, input bit lvl);
    for (int i = 0; i < n; i++) step(lvl, 1'b0);
  endtask

  task automatic do_reset(input int n, input bit lvl);
    for (int i = 0; i < n; i++) step(lvl, 1'b1);
  endtask

  bit er, ef, ev;
  int ep;

  // Monitor: pops whatever is due this cycle and compares against the DUT.
  always @(negedge clk) begin
    er = (rq.size() > 0) && (rq[0] == cyc);
    if (er) void'(rq.pop_front());
    ef = (fq.size() > 0) && (fq[0] == cyc);
    if (ef) void'(fq.pop_front());
    ev = (vq.size() > 0) && (vq[0].c == cyc);
    ep = ev ? vq[0].v : 0;
    if (ev) void'(vq.pop_front());
    while (lq.size() > 0 && lq[0].c <= cyc) begin
      cur_lock = lq[0].v[0];
      void'(lq.pop_front());
    end
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      cur_stall = sq[0].v[0];
      void'(sq.pop_front());
    end
    chk("rise_tick", int'(rise_tick), int'(er));
    chk("fall_tick", int'(fall_tick), int'(ef));
    chk("period_vld", int'(period_vld), int'(ev));
    if (ev && period_vld) chk("period", int'(period), ep);
    chk("locked", int'(locked), int'(cur_lock));
    chk("stall", int'(stall), int'(cur_stall));
    if (in_rst) chk("reset_period", int'(period), 0);
  end

  initial begin
    int r;
    // Reset, then divider N=6 for about 100 cycles.
    do_reset(5, 1'b0);
    periods(9, 6, 6);
    // Release reset while slow_clk is already high.
    do_reset(3, 1'b1);
    periods(5, 6, 6);
    // One stretched high phase (period 15), then relock.
    periods(1, 9, 6);
    periods(4, 6, 6);
    // Stopped divider: 40 cycles low, then restart.
    hold(40, 1'b0);
    periods(5, 6, 6);
    // Reset in the middle of a period while locked.
    hold(4, 1'b1);
    do_reset(3, 1'b0);
    periods(9, 6, 6);
    // Random mix of nominal, jittered, stopped and reset episodes.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0) do_reset($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      else if (r == 1) hold($urandom_range(30, 45), 1'b0);
      else if (r < 12) periods(1, 6, 6);
      else periods(1, $urandom_range(3, 9), $urandom_range(3, 9));
    end
    periods(4, 6, 6);
    hold(45, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
